// File: rtl/fetch_pc_pkg.sv
// Shared types for the fetch PC unit: BTB counter encoding, entry layout and
// saturating counter helpers.
package fetch_pc_pkg;

  localparam int unsigned BTB_XLEN  = 32;
  localparam int unsigned BTB_DEPTH = 16;
  localparam int unsigned BTB_IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned BTB_TAG_W = BTB_XLEN - BTB_IDX_W - 2;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_XLEN-1:0]  target;
    ctr_t                 ctr;
  } btb_entry_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// one-cycle update from execute, async clear of the valid bits only.
module fetch_btb
  import fetch_pc_pkg::*;
#(
  parameter int unsigned XLEN        = BTB_XLEN,
  parameter int unsigned BTB_ENTRIES = BTB_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  btb_entry_t        mem [BTB_ENTRIES];
  btb_entry_t        lk_e;
  btb_entry_t        up_e;
  btb_entry_t        wr_e;
  logic [IDX_W-1:0]  lk_idx;
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [TAG_W-1:0]  up_tag;
  logic              lk_hit;
  logic              up_hit;
  logic              up_en;
  logic              unused_bits;

  assign lk_idx      = lookup_pc[IDX_W+1:2];
  assign lk_tag      = lookup_pc[XLEN-1:IDX_W+2];
  assign up_idx      = upd_pc[IDX_W+1:2];
  assign up_tag      = upd_pc[XLEN-1:IDX_W+2];
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  always_comb begin
    lk_e        = mem[lk_idx];
    lk_hit      = lk_e.valid && (lk_e.tag == BTB_TAG_W'(lk_tag));
    pred_taken  = lk_hit && (lk_e.ctr inside {WT, ST});
    pred_target = pred_taken ? XLEN'(lk_e.target) : '0;
  end

  // Miss + not-taken leaves the entry alone so a cold branch cannot evict a
  // trained alias sharing the same index.
  always_comb begin
    up_e   = mem[up_idx];
    up_hit = up_e.valid && (up_e.tag == BTB_TAG_W'(up_tag));
    wr_e   = up_e;
    up_en  = 1'b0;
    if (upd_valid) begin
      if (up_hit) begin
        up_en = 1'b1;
        if (upd_taken) begin
          wr_e.ctr    = sat_inc(up_e.ctr);
          wr_e.target = BTB_XLEN'(upd_target);
        end else begin
          wr_e.ctr = sat_dec(up_e.ctr);
        end
      end else if (upd_taken) begin
        up_en       = 1'b1;
        wr_e.valid  = 1'b1;
        wr_e.tag    = BTB_TAG_W'(up_tag);
        wr_e.target = BTB_XLEN'(upd_target);
        wr_e.ctr    = WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        mem[i].valid <= 1'b0;
      end
    end else if (up_en) begin
      mem[up_idx] <= wr_e;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register with trap/redirect/stall/BTB/sequential next-PC
// selection for the RV32I pipeline.
module fetch_pc_unit
  import fetch_pc_pkg::*;
#(
  parameter int unsigned     XLEN        = BTB_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int unsigned     BTB_ENTRIES = BTB_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            redirect_e,
  input  logic [XLEN-1:0] redirect_pc_e,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            btb_upd_valid,
  input  logic [XLEN-1:0] btb_upd_pc,
  input  logic [XLEN-1:0] btb_upd_target,
  input  logic            btb_upd_taken,
  output logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] next_pc;

  fetch_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (pc_q),
    .upd_valid   (btb_upd_valid),
    .upd_pc      (btb_upd_pc),
    .upd_target  (btb_upd_target),
    .upd_taken   (btb_upd_taken),
    .pred_taken  (pred_taken_f),
    .pred_target (pred_target_f)
  );

  // Trap and redirect outrank stall; the prediction only steers an unstalled PC.
  always_comb begin
    next_pc = pc_q + XLEN'(4);
    if (trap_valid) begin
      next_pc = trap_pc;
    end else if (redirect_e) begin
      next_pc = redirect_pc_e;
    end else if (stall_f) begin
      next_pc = pc_q;
    end else if (pred_taken_f) begin
      next_pc = pred_target_f;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= next_pc;
    end
  end

  assign pc_f = pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a behavioural next-PC/BTB model pushes
// expected outputs per driven cycle; they are popped and compared after the edge.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0;
  logic        redirect_e = 1'b0;
  logic [31:0] redirect_pc_e = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        btb_upd_valid = 1'b0;
  logic [31:0] btb_upd_pc = '0;
  logic [31:0] btb_upd_target = '0;
  logic        btb_upd_taken = 1'b0;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;

  fetch_pc_unit #(
    .RESET_VEC (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_f        (stall_f),
    .redirect_e     (redirect_e),
    .redirect_pc_e  (redirect_pc_e),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .btb_upd_valid  (btb_upd_valid),
    .btb_upd_pc     (btb_upd_pc),
    .btb_upd_target (btb_upd_target),
    .btb_upd_taken  (btb_upd_taken),
    .pc_f           (pc_f),
    .pred_taken_f   (pred_taken_f),
    .pred_target_f  (pred_target_f)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: 16-entry direct-mapped BTB, 2-bit counters.
  logic [31:0] m_pc;
  logic        m_v   [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;
  exp_t sb[$];

  function automatic void m_reset();
    m_pc = 32'h0000_0100;
    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] tg);
    int i;
    logic hit;
    i   = int'(pc[5:2]);
    hit = m_v[i] && (m_tag[i] == pc[31:6]);
    pt  = hit && (m_ctr[i] >= 2);
    tg  = pt ? m_tgt[i] : 32'h0;
  endfunction

  function automatic void m_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    int i;
    i = int'(pc[5:2]);
    if (m_v[i] && (m_tag[i] == pc[31:6])) begin
      if (tk) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
        m_tgt[i] = tgt;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
    end else if (tk) begin
      m_v[i]   = 1'b1;
      m_tag[i] = pc[31:6];
      m_tgt[i] = tgt;
      m_ctr[i] = 2;
    end
  endfunction

  task automatic drive_cycle(input string tag, input logic st, input logic rd, input logic [31:0] rpc,
                             input logic tr, input logic [31:0] tpc, input logic uv,
                             input logic [31:0] upc, input logic [31:0] utgt, input logic utk);
    logic        pt;
    logic [31:0] tg;
    logic [31:0] nxt;
    exp_t        e;
    stall_f = st; redirect_e = rd; redirect_pc_e = rpc;
    trap_valid = tr; trap_pc = tpc;
    btb_upd_valid = uv; btb_upd_pc = upc; btb_upd_target = utgt; btb_upd_taken = utk;
    m_lookup(m_pc, pt, tg);
    if (tr)      nxt = tpc;
    else if (rd) nxt = rpc;
    else if (st) nxt = m_pc;
    else if (pt) nxt = tg;
    else         nxt = m_pc + 32'd4;
    if (uv) m_update(upc, utgt, utk);
    m_pc  = nxt;
    e.tag = tag;
    e.pc  = m_pc;
    m_lookup(m_pc, e.pt, e.tgt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({e.tag, ".pc"}, pc_f, e.pc);
    check_eq({e.tag, ".pt"}, {31'd0, pred_taken_f}, {31'd0, e.pt});
    check_eq({e.tag, ".tgt"}, pred_target_f, e.tgt);
  endtask

  task automatic idle(input string tag);
    drive_cycle(tag, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic stall(input string tag);
    drive_cycle(tag, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic go(input string tag, input logic [31:0] pc);
    drive_cycle(tag, 1'b0, 1'b1, pc, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic upd(input string tag, input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    drive_cycle(tag, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, pc, tgt, tk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.pc", pc_f, 32'h100);
    check_eq("rst.pt", {31'd0, pred_taken_f}, 32'd0);
    check_eq("rst.tgt", pred_target_f, 32'd0);
    rst = 1'b0;

    idle("seq1"); check_eq("seq1.const", pc_f, 32'h104);
    idle("seq2"); check_eq("seq2.const", pc_f, 32'h108);

    go("to8", 32'h8);
    for (int i = 0; i < 3; i++) begin
      stall("stall"); check_eq("stall.hold", pc_f, 32'h8);
    end
    idle("unstall"); check_eq("unstall.const", pc_f, 32'hC);
    drive_cycle("stall_redir", 1'b1, 1'b1, 32'h40, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    check_eq("stall_redir.const", pc_f, 32'h40);
    drive_cycle("trap_redir", 1'b0, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, '0, '0, 1'b0);
    check_eq("trap_redir.const", pc_f, 32'h200);

    upd("alloc10", 32'h10, 32'h80, 1'b1);
    go("hit10", 32'h10);
    check_eq("hit10.pt", {31'd0, pred_taken_f}, 32'd1);
    check_eq("hit10.tgt", pred_target_f, 32'h80);
    idle("follow"); check_eq("follow.const", pc_f, 32'h80);

    upd("nt1", 32'h10, 32'h0, 1'b0);
    upd("nt2", 32'h10, 32'h0, 1'b0);
    go("snt10", 32'h10); check_eq("snt10.pt", {31'd0, pred_taken_f}, 32'd0);
    idle("snt_seq"); check_eq("snt_seq.const", pc_f, 32'h14);

    upd("tk1", 32'h10, 32'h90, 1'b1);
    upd("tk2", 32'h10, 32'h90, 1'b1);
    upd("tk3", 32'h10, 32'h90, 1'b1);
    upd("tk4", 32'h10, 32'hA0, 1'b1);
    upd("st_nt", 32'h10, 32'h0, 1'b0);
    go("st10", 32'h10);
    check_eq("st10.pt", {31'd0, pred_taken_f}, 32'd1);
    check_eq("st10.tgt", pred_target_f, 32'hA0);
    idle("st_follow"); check_eq("st_follow.const", pc_f, 32'hA0);
    upd("wt_nt", 32'h10, 32'h0, 1'b0);
    go("wnt10", 32'h10); check_eq("wnt10.pt", {31'd0, pred_taken_f}, 32'd0);

    upd("retrain", 32'h10, 32'h80, 1'b1);
    go("alias50", 32'h50); check_eq("alias50.pt", {31'd0, pred_taken_f}, 32'd0);
    idle("alias_seq"); check_eq("alias_seq.const", pc_f, 32'h54);
    upd("alias_nt", 32'h50, 32'h0, 1'b0);
    go("intact10", 32'h10);
    check_eq("intact10.pt", {31'd0, pred_taken_f}, 32'd1);
    check_eq("intact10.tgt", pred_target_f, 32'h80);
    upd("nobypass", 32'h10, 32'h0, 1'b0);
    check_eq("nobypass.const", pc_f, 32'h80);

    go("wrap_hi", 32'hFFFF_FFFC);
    idle("wrap0"); check_eq("wrap0.const", pc_f, 32'h0);
    idle("wrap4"); check_eq("wrap4.const", pc_f, 32'h4);

    for (int i = 0; i < 60; i++) begin
      drive_cycle("rand",
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  32'($urandom_range(0, 63)) << 2, ($urandom_range(0, 19) == 0),
                  32'($urandom_range(64, 127)) << 2, ($urandom_range(0, 2) == 0),
                  32'($urandom_range(0, 63)) << 2, 32'($urandom_range(0, 63)) << 2,
                  1'($urandom_range(0, 1)));
    end

    upd("pre_rst_a", 32'h10, 32'h80, 1'b1);
    upd("pre_rst_b", 32'h10, 32'h80, 1'b1);
    go("pre_rst_hit", 32'h10);
    check_eq("pre_rst_hit.pt", {31'd0, pred_taken_f}, 32'd1);
    btb_upd_valid = 1'b1; btb_upd_pc = 32'h90; btb_upd_target = 32'h300; btb_upd_taken = 1'b1;
    redirect_e = 1'b0; trap_valid = 1'b0; stall_f = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_eq("async_rst.pc", pc_f, 32'h100);
    check_eq("async_rst.pt", {31'd0, pred_taken_f}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    btb_upd_valid = 1'b0;
    m_reset();
    check_eq("rst_hold.pc", pc_f, 32'h100);
    go("post_rst10", 32'h10); check_eq("post_rst10.pt", {31'd0, pred_taken_f}, 32'd0);
    go("post_rst90", 32'h90); check_eq("post_rst90.pt", {31'd0, pred_taken_f}, 32'd0);
    idle("post_rst_seq"); check_eq("post_rst_seq.const", pc_f, 32'h94);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
